// File: rtl/intersection_controller.sv
// Two-direction traffic light sequencer: NS-green, NS-yellow, all-red, EW-green, EW-yellow, all-red,
// timed by a seconds tick, with programmable phase durations and an EW demand sensor.
module intersection_controller #(
    parameter int CLK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inst_send,
    input  logic       inst_go,
    input  logic [1:0] cfg_sel,
    input  logic [3:0] input_time,
    input  logic       ew_req,
    output logic [1:0] ns_color,
    output logic [1:0] ew_color,
    output logic       running,
    output logic [2:0] phase,
    output logic [3:0] sec_left
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_NSG  = 3'd1;
    localparam logic [2:0] ST_NSY  = 3'd2;
    localparam logic [2:0] ST_AR1  = 3'd3;
    localparam logic [2:0] ST_EWG  = 3'd4;
    localparam logic [2:0] ST_EWY  = 3'd5;
    localparam logic [2:0] ST_AR2  = 3'd6;

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;

    logic [2:0]  phase_q, phase_d, nxt_s;
    logic [3:0]  sec_q, sec_d;
    logic        run_q, run_d;
    logic        req_q, req_d;
    logic [31:0] presc_q, presc_d;
    logic        tick_s;
    logic [1:0]  nsc_q, nsc_d, ewc_q, ewc_d;
    logic [3:0]  t_nsg_q, t_nsg_d, t_ewg_q, t_ewg_d, t_y_q, t_y_d, t_ar_q, t_ar_d;

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        case (p)
            ST_NSG:  return ST_NSY;
            ST_NSY:  return ST_AR1;
            ST_AR1:  return ST_EWG;
            ST_EWG:  return ST_EWY;
            ST_EWY:  return ST_AR2;
            ST_AR2:  return ST_NSG;
            default: return ST_IDLE;
        endcase
    endfunction

    // A stored zero still gives a one-second phase so the sequence can never stall at sec_left=0.
    function automatic logic [3:0] phase_len(input logic [2:0] p, input logic [3:0] nsg,
                                             input logic [3:0] ewg, input logic [3:0] y,
                                             input logic [3:0] ar);
        logic [3:0] t;
        case (p)
            ST_NSG:          t = nsg;
            ST_EWG:          t = ewg;
            ST_NSY, ST_EWY:  t = y;
            default:         t = ar;
        endcase
        if (t == 4'd0) begin
            return 4'd1;
        end else begin
            return t;
        end
    endfunction

    function automatic logic [1:0] ns_of(input logic [2:0] p);
        case (p)
            ST_NSG:  return C_GRN;
            ST_NSY:  return C_YEL;
            default: return C_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_of(input logic [2:0] p);
        case (p)
            ST_EWG:  return C_GRN;
            ST_EWY:  return C_YEL;
            default: return C_RED;
        endcase
    endfunction

    assign tick_s = run_q && (presc_q == 32'(CLK_DIV - 1));
    assign nxt_s  = next_phase(phase_q);

    // Next-state: run control, config writes, tick-driven phase timing and EW demand latch.
    always_comb begin
        phase_d = phase_q;
        sec_d   = sec_q;
        run_d   = run_q;
        presc_d = presc_q;
        t_nsg_d = t_nsg_q;
        t_ewg_d = t_ewg_q;
        t_y_d   = t_y_q;
        t_ar_d  = t_ar_q;
        if (inst_go) begin
            presc_d = 32'd0;
            if (run_q) begin
                run_d   = 1'b0;
                phase_d = ST_IDLE;
                sec_d   = 4'd0;
            end else begin
                run_d   = 1'b1;
                phase_d = ST_NSG;
                sec_d   = phase_len(ST_NSG, t_nsg_q, t_ewg_q, t_y_q, t_ar_q);
            end
        end else begin
            if (inst_send) begin
                case (cfg_sel)
                    2'd0:    t_nsg_d = input_time;
                    2'd1:    t_ewg_d = input_time;
                    2'd2:    t_y_d   = input_time;
                    default: t_ar_d  = input_time;
                endcase
            end else begin
                t_nsg_d = t_nsg_q;
            end
            if (run_q) begin
                presc_d = tick_s ? 32'd0 : presc_q + 32'd1;
                if (!tick_s) begin
                    sec_d = sec_q;
                end else if (sec_q > 4'd1) begin
                    sec_d = sec_q - 4'd1;
                end else if ((phase_q == ST_NSG) && !req_q && !ew_req) begin
                    // No EW demand: rest in NS green and re-check on every tick.
                    sec_d = 4'd1;
                end else begin
                    phase_d = nxt_s;
                    sec_d   = phase_len(nxt_s, t_nsg_q, t_ewg_q, t_y_q, t_ar_q);
                end
            end else begin
                presc_d = 32'd0;
            end
        end
        if ((phase_d == ST_EWG) && (phase_q != ST_EWG)) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q | ew_req;
        end
        nsc_d = ns_of(phase_d);
        ewc_d = ew_of(phase_d);
    end

    // State and output registers with synchronous reset to the idle, all-red, default-timing state.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= ST_IDLE;
            sec_q   <= 4'd0;
            run_q   <= 1'b0;
            req_q   <= 1'b0;
            presc_q <= 32'd0;
            nsc_q   <= C_RED;
            ewc_q   <= C_RED;
            t_nsg_q <= 4'd10;
            t_ewg_q <= 4'd10;
            t_y_q   <= 4'd3;
            t_ar_q  <= 4'd1;
        end else begin
            phase_q <= phase_d;
            sec_q   <= sec_d;
            run_q   <= run_d;
            req_q   <= req_d;
            presc_q <= presc_d;
            nsc_q   <= nsc_d;
            ewc_q   <= ewc_d;
            t_nsg_q <= t_nsg_d;
            t_ewg_q <= t_ewg_d;
            t_y_q   <= t_y_d;
            t_ar_q  <= t_ar_d;
        end
    end

    assign ns_color = nsc_q;
    assign ew_color = ewc_q;
    assign running  = run_q;
    assign phase    = phase_q;
    assign sec_left = sec_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed vector table for the timing corners, then a
// constrained-random run checked against a behavioural model plus per-cycle safety checks.
module tb_intersection_controller;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inst_send = 1'b0;
    logic       inst_go = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic [3:0] input_time = 4'd0;
    logic       ew_req = 1'b0;
    logic [1:0] ns_color, ew_color;
    logic       running;
    logic [2:0] phase;
    logic [3:0] sec_left;

    int n_checks = 0;
    int n_fail   = 0;

    intersection_controller #(.CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .inst_send(inst_send), .inst_go(inst_go), .cfg_sel(cfg_sel),
        .input_time(input_time), .ew_req(ew_req), .ns_color(ns_color), .ew_color(ew_color),
        .running(running), .phase(phase), .sec_left(sec_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit g; bit s; logic [1:0] sel; logic [3:0] tm; bit e; int w;
        int ph; int run; int nsc; int ewc; int sec;
    } vec_t;
    vec_t vecs[$];

    // Reference model: phase order, timing field and lamp colours as lookup tables.
    int succ[7]   = '{0, 2, 3, 4, 5, 6, 1};
    int fld[7]    = '{0, 0, 2, 3, 1, 2, 3};
    int ns_tab[7] = '{0, 2, 1, 0, 0, 0, 0};
    int ew_tab[7] = '{0, 0, 0, 0, 2, 1, 0};
    int m_t[4];
    int m_phase, m_sec, m_cnt;
    bit m_run, m_req;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input int r, input int g, input int s, input int sel, input int tm,
                         input int e);
        @(negedge clk);
        rst        = (r != 0);
        inst_go    = (g != 0);
        inst_send  = (s != 0);
        cfg_sel    = 2'(sel);
        input_time = 4'(tm);
        ew_req     = (e != 0);
        @(posedge clk);
        #1;
        chk("safety_both_nonred", int'(ns_color != 2'b00 && ew_color != 2'b00), 0);
        chk("safety_color_11", int'(ns_color == 2'b11 || ew_color == 2'b11), 0);
        chk("safety_sec_zero_running", int'(running && sec_left == 4'd0), 0);
    endtask

    function automatic int max1(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic model_step(input int r, input int g, input int s, input int sel,
                              input int tm, input int e);
        bit second_done;
        bit entered_ewg;
        entered_ewg = 1'b0;
        if (r != 0) begin
            m_t = '{10, 10, 3, 1};
            m_phase = 0; m_sec = 0; m_cnt = 0; m_run = 1'b0; m_req = 1'b0;
            return;
        end
        if (g != 0) begin
            m_cnt = 0;
            if (m_run) begin
                m_run = 1'b0; m_phase = 0; m_sec = 0;
            end else begin
                m_run = 1'b1; m_phase = 1; m_sec = max1(m_t[0]);
            end
        end else begin
            if (m_run) begin
                second_done = (m_cnt == DIV - 1);
                m_cnt = (m_cnt + 1) % DIV;
                if (second_done) begin
                    if (m_sec > 1) m_sec--;
                    else if (m_phase == 1 && !m_req && e == 0) m_sec = 1;
                    else begin
                        m_phase = succ[m_phase];
                        m_sec = max1(m_t[fld[m_phase]]);
                        entered_ewg = (m_phase == 4);
                    end
                end
            end
            if (s != 0) m_t[sel] = tm;
        end
        m_req = entered_ewg ? 1'b0 : (m_req | (e != 0));
    endtask

    task automatic add(input int r, input int g, input int s, input int sel, input int tm,
                       input int e, input int w, input int ph, input int run, input int nsc,
                       input int ewc, input int sec);
        vec_t v;
        v.r = (r != 0); v.g = (g != 0); v.s = (s != 0); v.sel = 2'(sel); v.tm = 4'(tm);
        v.e = (e != 0); v.w = w; v.ph = ph; v.run = run; v.nsc = nsc; v.ewc = ewc; v.sec = sec;
        vecs.push_back(v);
    endtask

    initial begin
        int g, s, sel, tm, e, r, bias;
        // r g s sel tm e  wait | phase run ns ew sec   (sec -1: not checked)
        add(1,0,0,0,0,1,  0,   0,0,0,0,0);
        add(0,1,0,0,0,1,  0,   1,1,2,0,10);
        add(0,0,0,0,0,1, 38,   1,1,2,0,1);
        add(0,0,0,0,0,1,  0,   2,1,1,0,3);
        add(0,0,0,0,0,1, 10,   2,1,1,0,1);
        add(0,0,0,0,0,1,  0,   3,1,0,0,1);
        add(0,0,0,0,0,1,  3,   4,1,0,2,10);
        add(0,0,0,0,0,1, 39,   5,1,0,1,3);
        add(0,0,0,0,0,1, 11,   6,1,0,0,1);
        add(0,0,0,0,0,1,  3,   1,1,2,0,10);
        add(0,0,0,0,0,1, 39,   2,1,1,0,3);
        add(0,0,0,0,0,1, 15,   4,1,0,2,10);
        add(0,0,0,0,0,1, 39,   5,1,0,1,3);
        add(0,0,1,2,0,1,  0,   5,1,0,1,3);
        add(0,0,0,0,0,1, 10,   6,1,0,0,1);
        add(0,0,0,0,0,1,  3,   1,1,2,0,10);
        add(0,0,0,0,0,1, 39,   2,1,1,0,1);
        add(0,0,0,0,0,1,  3,   3,1,0,0,1);
        add(0,0,0,0,0,1,  3,   4,1,0,2,10);
        add(0,0,0,0,0,1, 39,   5,1,0,1,1);
        add(0,0,0,0,0,1,  1,   5,1,0,1,1);
        add(0,1,0,0,0,1,  0,   0,0,0,0,-1);
        add(0,1,0,0,0,1,  0,   1,1,2,0,10);
        add(0,1,1,0,5,1,  0,   0,0,0,0,-1);
        add(0,1,0,0,0,1,  0,   1,1,2,0,10);
        add(0,0,0,0,0,1, 39,   2,1,1,0,1);
        add(0,0,0,0,0,1,  3,   3,1,0,0,1);
        add(0,0,0,0,0,1,  3,   4,1,0,2,10);
        add(0,0,0,0,0,1,  5,   4,1,0,2,9);
        add(1,0,0,0,0,1,  0,   0,0,0,0,0);
        add(0,1,0,0,0,1,  0,   1,1,2,0,10);
        add(0,0,0,0,0,1, 39,   2,1,1,0,3);
        add(1,0,0,0,0,0,  0,   0,0,0,0,0);
        add(0,1,0,0,0,0,  0,   1,1,2,0,10);
        add(0,0,0,0,0,0, 39,   1,1,2,0,1);
        add(0,0,0,0,0,0, 99,   1,1,2,0,1);
        add(0,0,0,0,0,1,  0,   1,1,2,0,1);
        add(0,0,0,0,0,0,  1,   1,1,2,0,1);
        add(0,0,0,0,0,0,  0,   2,1,1,0,3);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].g, vecs[i].s, vecs[i].sel, vecs[i].tm, vecs[i].e);
            for (int k = 0; k < vecs[i].w; k++) cycle(0, 0, 0, 0, 0, vecs[i].e);
            chk($sformatf("vec%0d.phase", i), int'(phase), vecs[i].ph);
            chk($sformatf("vec%0d.running", i), int'(running), vecs[i].run);
            chk($sformatf("vec%0d.ns_color", i), int'(ns_color), vecs[i].nsc);
            chk($sformatf("vec%0d.ew_color", i), int'(ew_color), vecs[i].ewc);
            if (vecs[i].sec >= 0) chk($sformatf("vec%0d.sec_left", i), int'(sec_left), vecs[i].sec);
        end

        // Constrained-random run against the model.
        model_step(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        bias = 2;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) bias = (bias == 2) ? 60 : 2;
            g   = ($urandom_range(0, 249) == 0) ? 1 : 0;
            if (c == 5) g = 1;
            s   = ($urandom_range(0, 15) == 0) ? 1 : 0;
            sel = int'($urandom_range(0, 3));
            tm  = int'($urandom_range(0, 15));
            e   = (int'($urandom_range(0, 99)) < bias) ? 1 : 0;
            r   = ($urandom_range(0, 1999) == 0) ? 1 : 0;
            model_step(r, g, s, sel, tm, e);
            cycle(r, g, s, sel, tm, e);
            chk($sformatf("rnd%0d.phase", c), int'(phase), m_phase);
            chk($sformatf("rnd%0d.running", c), int'(running), int'(m_run));
            chk($sformatf("rnd%0d.ns_color", c), int'(ns_color), ns_tab[m_phase]);
            chk($sformatf("rnd%0d.ew_color", c), int'(ew_color), ew_tab[m_phase]);
            if (m_run) chk($sformatf("rnd%0d.sec_left", c), int'(sec_left), m_sec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
